boot_load_ctrl: RTL and testbench

//  Boot sequencer that loads the processor's IRAM and then its DRAM from an external
//  16-bit word stream, then releases the processor to run. It drives the external

---
 rtl/boot_load_ctrl_if.sv | 21 ++
 rtl/boot_load_ctrl.sv | 153 +++++++++++++++
 tb/tb_boot_load_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/boot_load_ctrl_if.sv
// Boot stream port: word source to the boot load controller.
// Plain valid/ready; the source holds in_data until accepted.
interface boot_load_ctrl_if #(
    parameter int DATA_W = 16
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/boot_load_ctrl.sv
// Boot sequencer: streams IRAM then DRAM images into the core's
// external load port, then holds the core in RUN until it halts.
module boot_load_ctrl #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 9,
    parameter int BASE_ADDR = 1,
    parameter int MAX_WORDS = 511
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              boot_req,
    boot_load_ctrl_if.slave   strm,
    output logic [ADDR_W-1:0] addr_ext,
    output logic [DATA_W-1:0] Data_in_ins,
    output logic [DATA_W-1:0] Data_in_dram,
    output logic              iram_write_ext,
    output logic              dram_write_ext,
    output logic              start_2,
    output logic              start_3,
    output logic              start,
    input  logic              proc_halt,
    output logic              busy,
    output logic              error
);

    localparam int CW = ADDR_W + 1;

    typedef enum logic [3:0] {
        IDLE, I_HDR, I_WR, I_WAIT,
        D_HDR, D_WR, D_WAIT, RUN, ERR
    } state_t;

    state_t        state, state_n;
    logic          gap, gap_n;
    logic [CW-1:0] cnt;
    logic          rdy, acc, last;
    logic          hdr_bad, hdr_zero;

    // gap is the dead cycle with no phase flag between phases
    assign rdy = !gap && (state == I_HDR || state == I_WAIT ||
                          state == D_HDR || state == D_WAIT);
    assign acc = rdy & strm.in_valid;
    assign strm.in_ready = rdy;

    assign hdr_bad  = strm.in_data > DATA_W'(MAX_WORDS);
    assign hdr_zero = strm.in_data == '0;
    assign last     = cnt == CW'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            gap   <= 1'b0;
        end else begin
            state <= state_n;
            gap   <= gap_n;
        end
    end

    always_comb begin
        state_n        = state;
        gap_n          = 1'b0;
        start_2        = 1'b0;
        start_3        = 1'b0;
        start          = 1'b0;
        iram_write_ext = 1'b0;
        dram_write_ext = 1'b0;
        error          = state == ERR;
        busy           = state != IDLE && state != ERR;
        if (!gap) begin
            unique case (state)
                IDLE: begin
                    if (boot_req) state_n = I_HDR;
                end
                I_HDR: begin
                    start_2 = 1'b1;
                    if (acc) begin
                        if (hdr_bad) begin
                            state_n = ERR;
                        end else if (hdr_zero) begin
                            state_n = D_HDR;
                            gap_n   = 1'b1;
                        end else begin
                            state_n = I_WAIT;
                        end
                    end
                end
                I_WAIT: begin
                    start_2 = 1'b1;
                    if (acc) state_n = I_WR;
                end
                I_WR: begin
                    start_2        = 1'b1;
                    iram_write_ext = 1'b1;
                    state_n        = last ? D_HDR : I_WAIT;
                    gap_n          = last;
                end
                D_HDR: begin
                    start_3 = 1'b1;
                    if (acc) begin
                        if (hdr_bad) begin
                            state_n = ERR;
                        end else if (hdr_zero) begin
                            state_n = RUN;
                            gap_n   = 1'b1;
                        end else begin
                            state_n = D_WAIT;
                        end
                    end
                end
                D_WAIT: begin
                    start_3 = 1'b1;
                    if (acc) state_n = D_WR;
                end
                D_WR: begin
                    start_3        = 1'b1;
                    dram_write_ext = 1'b1;
                    state_n        = last ? RUN : D_WAIT;
                    gap_n          = last;
                end
                RUN: begin
                    start = 1'b1;
                    if (proc_halt) state_n = IDLE;
                end
                ERR: begin
                    if (boot_req) state_n = I_HDR;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // addr holds on the last word so it never steps past MAX_WORDS
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            addr_ext     <= ADDR_W'(BASE_ADDR);
            Data_in_ins  <= '0;
            Data_in_dram <= '0;
        end else begin
            if (acc && (state == I_HDR || state == D_HDR)) begin
                cnt      <= strm.in_data[CW-1:0];
                addr_ext <= ADDR_W'(BASE_ADDR);
            end
            if (acc && state == I_WAIT) Data_in_ins  <= strm.in_data;
            if (acc && state == D_WAIT) Data_in_dram <= strm.in_data;
            if (iram_write_ext || dram_write_ext) begin
                cnt <= cnt - CW'(1);
                if (!last) addr_ext <= addr_ext + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Bench for boot_load_ctrl: table of load scenarios with a write
// scoreboard, plus hand-written reset-abort and error sequences.
module tb_boot_load_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        boot_req = 1'b0;
    logic        proc_halt = 1'b0;
    logic [8:0]  addr_ext;
    logic [15:0] Data_in_ins, Data_in_dram;
    logic        iram_write_ext, dram_write_ext;
    logic        start_2, start_3, start, busy, error;

    boot_load_ctrl_if #(.DATA_W(16)) strm ();

    boot_load_ctrl dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .boot_req       (boot_req),
        .strm           (strm),
        .addr_ext       (addr_ext),
        .Data_in_ins    (Data_in_ins),
        .Data_in_dram   (Data_in_dram),
        .iram_write_ext (iram_write_ext),
        .dram_write_ext (dram_write_ext),
        .start_2        (start_2),
        .start_3        (start_3),
        .start          (start),
        .proc_halt      (proc_halt),
        .busy           (busy),
        .error          (error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int i_n, i_b, i_s;
        int d_n, d_b, d_s;
        int gap;
        bit i_err, d_err;
        int exp_iw, exp_dw;
    } vec_t;

    vec_t        tv[7];
    logic [24:0] iq[$];
    logic [24:0] dq[$];
    int          ncmp = 0, nbad = 0;
    int          cyc = 0, last_dw = 0;
    int          iw_cnt = 0, dw_cnt = 0;
    logic [2:0]  prev_fl = 3'b000;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    always @(posedge clock) cyc++;

    // scoreboard and phase-flag monitor
    always @(negedge clock) begin
        logic [24:0] e;
        logic [2:0]  fl;
        fl = {start, start_3, start_2};
        ncmp++;
        if ($countones(fl) > 1 ||
            (prev_fl != 0 && fl != 0 && fl != prev_fl)) begin
            nbad++;
            $display("FAIL flags: got %b after %b", fl, prev_fl);
        end
        prev_fl = fl;
        if (iram_write_ext) begin
            iw_cnt++;
            if (iq.size() == 0) begin
                ncmp++; nbad++;
                $display("FAIL iram_unexp: strobe addr %0d", addr_ext);
            end else begin
                e = iq.pop_front();
                chk("iram_addr", 32'(addr_ext), 32'(e[24:16]));
                chk("iram_data", 32'(Data_in_ins), 32'(e[15:0]));
                chk("iram_phase", 32'(start_2), 32'd1);
            end
        end
        if (dram_write_ext) begin
            dw_cnt++;
            last_dw = cyc;
            if (dq.size() == 0) begin
                ncmp++; nbad++;
                $display("FAIL dram_unexp: strobe addr %0d", addr_ext);
            end else begin
                e = dq.pop_front();
                chk("dram_addr", 32'(addr_ext), 32'(e[24:16]));
                chk("dram_data", 32'(Data_in_dram), 32'(e[15:0]));
                chk("dram_phase", 32'(start_3), 32'd1);
            end
        end
    end

    task automatic pulse_boot();
        boot_req = 1'b1;
        @(negedge clock);
        boot_req = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input int gap);
        int n = 0;
        while ($urandom_range(99) < gap) @(negedge clock);
        strm.in_valid = 1'b1;
        strm.in_data  = w;
        while (!strm.in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) begin
            ncmp++; nbad++;
            $display("FAIL ready_timeout: word %0h never taken", w);
        end
        @(negedge clock);
        strm.in_valid = 1'b0;
    endtask

    task automatic run_load(input vec_t v);
        int i0 = iw_cnt, d0 = dw_cnt, n = 0;
        logic [15:0] w;
        bit ran = 0;
        pulse_boot();
        chk("boot_start", {busy, error, start_2}, 3'b101);
        send_word(16'(v.i_n), v.gap);
        if (v.i_err) begin
            chk("i_err", {error, busy, strm.in_ready, start_2,
                start_3, start, iram_write_ext}, 7'b1000000);
        end else begin
            for (int k = 0; k < v.i_n; k++) begin
                w = 16'(v.i_b + v.i_s * k);
                iq.push_back({9'(1 + k), w});
                send_word(w, v.gap);
            end
            send_word(16'(v.d_n), v.gap);
            if (v.d_err) begin
                chk("d_err", {error, busy, strm.in_ready, start_3,
                    start, dram_write_ext}, 6'b100000);
            end else begin
                for (int k = 0; k < v.d_n; k++) begin
                    w = 16'(v.d_b + v.d_s * k);
                    dq.push_back({9'(1 + k), w});
                    send_word(w, v.gap);
                end
                while (!start && n < 20) begin
                    @(negedge clock);
                    n++;
                end
                chk("start_seen", 32'(start), 32'd1);
                if (v.d_n > 0) chk("start_lat", 32'(cyc - last_dw), 32'd2);
                ran = 1;
            end
        end
        chk("iram_count", 32'(iw_cnt - i0), 32'(v.exp_iw));
        chk("dram_count", 32'(dw_cnt - d0), 32'(v.exp_dw));
        chk("q_empty", 32'(iq.size() + dq.size()), 32'd0);
        if (ran) begin
            pulse_boot();
            @(negedge clock);
            chk("run_hold", {start, start_2, busy, strm.in_ready}, 4'b1010);
            proc_halt = 1'b1;
            @(negedge clock);
            proc_halt = 1'b0;
            chk("halt", {start, busy, error}, 3'b000);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        tv[0] = '{3, 10, 10, 2, 7, 1, 0, 1'b0, 1'b0, 3, 2};
        tv[1] = '{0, 0, 0, 1, 5, 0, 0, 1'b0, 1'b0, 0, 1};
        tv[2] = '{512, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 0, 0};
        tv[3] = '{2, 100, 3, 2, 200, 3, 20, 1'b0, 1'b0, 2, 2};
        tv[4] = '{1, 1, 1, 512, 0, 0, 0, 1'b0, 1'b1, 1, 0};
        tv[5] = '{511, 4096, 1, 511, 32768, 3, 50, 1'b0, 1'b0, 511, 511};
        tv[6] = '{4, 65535, -1, 0, 0, 0, 30, 1'b0, 1'b0, 4, 0};

        strm.in_valid = 1'b0;
        strm.in_data  = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        @(negedge clock);
        chk("rst_addr", 32'(addr_ext), 32'd1);
        chk("rst_data", {Data_in_ins, Data_in_dram}, 32'd0);
        chk("rst_ctl", {iram_write_ext, dram_write_ext, start_2, start_3,
            start, busy, error, strm.in_ready}, 8'd0);
        reset_n = 1'b1;
        @(negedge clock);

        for (int t = 0; t < 7; t++) run_load(tv[t]);

        // abort in the middle of word 2's write strobe
        pulse_boot();
        send_word(16'd3, 0);
        iq.push_back({9'd1, 16'd10});
        send_word(16'd10, 0);
        iq.push_back({9'd2, 16'd20});
        send_word(16'd20, 0);
        chk("abort_in_wr", 32'(iram_write_ext), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_ctl", {iram_write_ext, start_2, busy, strm.in_ready},
            4'b0000);
        chk("abort_addr", 32'(addr_ext), 32'd1);
        chk("abort_data", 32'(Data_in_ins), 32'd0);
        chk("abort_q", 32'(iq.size()), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_load(tv[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nbad);
        $finish;
    end

endmodule
